// File: rtl/handshake_mc_if.sv
// rtl/handshake_mc_if.sv - per-channel handshake bundle for handshake_mc
//   ready   : producer has data, one bit per channel
//   ack     : consumer acknowledge, one bit per channel
//   req     : request, high while the channel is in SEND
//   busy    : channel is not idle
//   done    : one-cycle completion pulse
//   timeout : one-cycle abort pulse (only with HS_TIMEOUT_EN)
// master modport is the handshake_mc side, slave is the consumer side.
interface handshake_mc_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] ready;
  logic [NCH-1:0] ack;
  logic [NCH-1:0] req;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] done;
`ifdef HS_TIMEOUT_EN
  logic [NCH-1:0] timeout;
`endif

  modport master (
    input  ready,
    input  ack,
    output req,
    output busy,
    output done
`ifdef HS_TIMEOUT_EN
    , output timeout
`endif
  );

  modport slave (
    output ready,
    output ack,
    input  req,
    input  busy,
    input  done
`ifdef HS_TIMEOUT_EN
    , input timeout
`endif
  );
endinterface

// File: rtl/handshake_mc.sv
// rtl/handshake_mc.sv - NCH independent req/ack handshake channels
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   hs    : handshake_mc_if.master (ready/ack in, req/busy/done/timeout out)
// Optional macro HS_TIMEOUT_EN adds a per-channel SEND timeout and hs.timeout.
module handshake_mc #(
  parameter int NCH            = 4,
  parameter int PREP_CYCLES    = 4,
  parameter int FOUR_PHASE     = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset,
  handshake_mc_if.master hs
);

  // Zero prep cycles would give a zero-width counter; keep one bit that stays 0.
  localparam int PW = (PREP_CYCLES > 0) ? $clog2(PREP_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PREP_LAST = PW'((PREP_CYCLES > 0) ? PREP_CYCLES - 1 : 0);
`ifdef HS_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("handshake_mc: NCH must be 1..16");
  end
  if (PREP_CYCLES < 0 || PREP_CYCLES > 255) begin : g_bad_prep
    $error("handshake_mc: PREP_CYCLES must be 0..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("handshake_mc: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_SEND,
    ST_RELEASE
  } state_t;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          done_q, done_d;
`ifdef HS_TIMEOUT_EN
    logic [15:0]   tcnt_q, tcnt_d;
    logic          tout_q, tout_d;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= ST_IDLE;
        pcnt_q  <= '0;
        done_q  <= 1'b0;
`ifdef HS_TIMEOUT_EN
        tcnt_q  <= '0;
        tout_q  <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        pcnt_q  <= pcnt_d;
        done_q  <= done_d;
`ifdef HS_TIMEOUT_EN
        tcnt_q  <= tcnt_d;
        tout_q  <= tout_d;
`endif
      end
    end

    // Counters default to zero so they are cleared in every state that does
    // not explicitly advance them.
    always_comb begin
      state_d = state_q;
      pcnt_d  = '0;
      done_d  = 1'b0;
`ifdef HS_TIMEOUT_EN
      tcnt_d  = '0;
      tout_d  = 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          // Also taken in the done cycle, so back-to-back requests need no gap.
          if (hs.ready[i]) begin
            state_d = (PREP_CYCLES == 0) ? ST_SEND : ST_PREP;
          end
        end
        ST_PREP: begin
          if (pcnt_q == PREP_LAST) begin
            state_d = ST_SEND;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        ST_SEND: begin
          // ack in the expiry cycle takes precedence over the timeout.
          if (hs.ack[i]) begin
            if (FOUR_PHASE != 0) begin
              state_d = ST_RELEASE;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
`ifdef HS_TIMEOUT_EN
          else if (tcnt_q == TO_LAST) begin
            state_d = ST_IDLE;
            tout_d  = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 16'd1;
          end
`endif
        end
        ST_RELEASE: begin
          if (!hs.ack[i]) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign hs.req[i]  = (state_q == ST_SEND);
    assign hs.busy[i] = (state_q != ST_IDLE);
    assign hs.done[i] = done_q;
`ifdef HS_TIMEOUT_EN
    assign hs.timeout[i] = tout_q;
`endif
  end

endmodule

// File: tb/tb_handshake_mc.sv
// tb/tb_handshake_mc.sv - scoreboard testbench for handshake_mc
module tb_handshake_mc;

  localparam int K_REQ_R = 0;
  localparam int K_REQ_F = 1;
  localparam int K_DONE  = 2;
  localparam int K_TOUT  = 3;

  typedef struct {
    int dut;
    int ch;
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  handshake_mc_if #(.NCH(4)) if_a ();
  handshake_mc_if #(.NCH(1)) if_b ();
  handshake_mc_if #(.NCH(2)) if_c ();

  handshake_mc #(.NCH(4), .PREP_CYCLES(4), .FOUR_PHASE(0), .TIMEOUT_CYCLES(8)) u_a (
    .clk(clk), .reset(reset), .hs(if_a));
  handshake_mc #(.NCH(1), .PREP_CYCLES(0), .FOUR_PHASE(0), .TIMEOUT_CYCLES(64)) u_b (
    .clk(clk), .reset(reset), .hs(if_b));
  handshake_mc #(.NCH(2), .PREP_CYCLES(4), .FOUR_PHASE(1), .TIMEOUT_CYCLES(8)) u_c (
    .clk(clk), .reset(reset), .hs(if_c));

  logic [3:0] tout_a, tout_c;
`ifdef HS_TIMEOUT_EN
  assign tout_a = if_a.timeout;
  assign tout_c = {2'b00, if_c.timeout};
`else
  assign tout_a = 4'b0;
  assign tout_c = 4'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic string kname(input int kind);
    case (kind)
      K_REQ_R: return "req_rise";
      K_REQ_F: return "req_fall";
      K_DONE:  return "done";
      default: return "timeout";
    endcase
  endfunction

  task automatic expect_ev(input int d, input int ch, input int kind, input int c);
    exp_q.push_back('{d, ch, kind, c});
  endtask

  task automatic observe(input int d, input int ch, input int kind);
    int    idx;
    string tag;
    idx = -1;
    tag = $sformatf("d%0d_ch%0d_%s", d, ch, kname(kind));
    foreach (exp_q[k]) begin
      if (idx < 0 && exp_q[k].dut == d && exp_q[k].ch == ch && exp_q[k].kind == kind) idx = k;
    end
    if (idx < 0) begin
      check({tag, "_unexpected"}, cyc, -1);
    end else begin
      check(tag, cyc, exp_q[idx].cyc);
      exp_q.delete(idx);
    end
  endtask

  task automatic scan(input int d, input logic [3:0] rq, input logic [3:0] prv,
                      input logic [3:0] dn, input logic [3:0] to);
    for (int ch = 0; ch < 4; ch++) begin
      if (rq[ch] && !prv[ch]) observe(d, ch, K_REQ_R);
      if (!rq[ch] && prv[ch]) observe(d, ch, K_REQ_F);
      if (dn[ch]) observe(d, ch, K_DONE);
      if (to[ch]) observe(d, ch, K_TOUT);
    end
  endtask

  logic [3:0] pa = 4'b0, pb = 4'b0, pc = 4'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      scan(0, if_a.req, pa, if_a.done, tout_a);
      scan(1, {3'b000, if_b.req}, pb, {3'b000, if_b.done}, 4'b0);
      scan(2, {2'b00, if_c.req}, pc, {2'b00, if_c.done}, tout_c);
    end
    pa <= if_a.req;
    pb <= {3'b000, if_b.req};
    pc <= {2'b00, if_c.req};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    if_a.ready = '0; if_a.ack = '0;
    if_b.ready = '0; if_b.ack = '0;
    if_c.ready = '0; if_c.ack = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_outputs", {if_a.req, if_a.busy, if_a.done}, 0);
    check("rst_b_outputs", {if_b.req, if_b.busy, if_b.done}, 0);
    check("rst_c_outputs", {if_c.req, if_c.busy, if_c.done}, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    step();

    // Single-channel timing: two-phase with prep, zero prep, four-phase.
    t0 = cyc;
    expect_ev(0, 0, K_REQ_R, t0 + 5); expect_ev(0, 0, K_REQ_F, t0 + 8); expect_ev(0, 0, K_DONE, t0 + 8);
    expect_ev(1, 0, K_REQ_R, t0 + 1); expect_ev(1, 0, K_REQ_F, t0 + 4); expect_ev(1, 0, K_DONE, t0 + 4);
    expect_ev(2, 0, K_REQ_R, t0 + 5); expect_ev(2, 0, K_REQ_F, t0 + 8); expect_ev(2, 0, K_DONE, t0 + 11);
    for (int t = 0; t < 14; t++) begin
      if_a.ready = (t == 0) ? 4'b0001 : 4'b0000;
      if_a.ack   = (t == 7) ? 4'b0001 : 4'b0000;
      if_b.ready = (t == 0) ? 1'b1 : 1'b0;
      if_b.ack   = (t == 3) ? 1'b1 : 1'b0;
      if_c.ready = (t == 0) ? 2'b01 : 2'b00;
      if_c.ack   = (t >= 7 && t <= 9) ? 2'b01 : 2'b00;
      if (t == 2)  check("a_busy_prep_ready_low", if_a.busy, 4'b0001);
      if (t == 10) check("c_busy_release", if_c.busy, 2'b01);
      if (t == 11) check("c_busy_after_done", if_c.busy, 2'b00);
      step();
    end

    // Multi-channel, staggered acks, back-to-back on ch0, ack ignored on idle ch2.
    t0 = cyc;
    expect_ev(0, 0, K_REQ_R, t0 + 5);  expect_ev(0, 0, K_REQ_F, t0 + 6);  expect_ev(0, 0, K_DONE, t0 + 6);
    expect_ev(0, 0, K_REQ_R, t0 + 11); expect_ev(0, 0, K_REQ_F, t0 + 14); expect_ev(0, 0, K_DONE, t0 + 14);
    expect_ev(0, 1, K_REQ_R, t0 + 5);  expect_ev(0, 1, K_REQ_F, t0 + 10); expect_ev(0, 1, K_DONE, t0 + 10);
    expect_ev(0, 3, K_REQ_R, t0 + 5);  expect_ev(0, 3, K_REQ_F, t0 + 13); expect_ev(0, 3, K_DONE, t0 + 13);
    for (int t = 0; t < 17; t++) begin
      if_a.ready = (t == 0) ? 4'b1011 : (t == 6) ? 4'b0001 : 4'b0000;
      if_a.ack   = {(t == 12), (t == 6 || t == 7), (t == 9), (t == 5 || t == 13)};
      if (t == 8) check("a_ch2_idle_busy", if_a.busy[2], 1'b0);
      step();
    end
    if_a.ack = '0;

    // Reset mid-PREP (u_a ch0) and mid-SEND (u_b), then a full restart.
    t0 = cyc;
    expect_ev(1, 0, K_REQ_R, t0 + 1); expect_ev(1, 0, K_REQ_F, t0 + 4);
    expect_ev(0, 0, K_REQ_R, t0 + 10); expect_ev(0, 0, K_REQ_F, t0 + 12); expect_ev(0, 0, K_DONE, t0 + 12);
    for (int t = 0; t < 15; t++) begin
      reset      = (t == 3);
      if_a.ready = (t == 0 || t == 5) ? 4'b0001 : 4'b0000;
      if_a.ack   = (t == 11) ? 4'b0001 : 4'b0000;
      if_b.ready = (t == 0) ? 1'b1 : 1'b0;
      if (t == 3) check("a_busy_before_reset", if_a.busy, 4'b0001);
      if (t == 4) check("a_outputs_after_reset", {if_a.req, if_a.busy, if_a.done}, 0);
      if (t == 4) check("b_outputs_after_reset", {if_b.req, if_b.busy, if_b.done}, 0);
      step();
    end

`ifdef HS_TIMEOUT_EN
    // Timeout after 8 req-high cycles, then ack in the expiry cycle wins.
    t0 = cyc;
    expect_ev(0, 1, K_REQ_R, t0 + 5);  expect_ev(0, 1, K_REQ_F, t0 + 13); expect_ev(0, 1, K_TOUT, t0 + 13);
    expect_ev(0, 1, K_REQ_R, t0 + 19); expect_ev(0, 1, K_REQ_F, t0 + 27); expect_ev(0, 1, K_DONE, t0 + 27);
    for (int t = 0; t < 31; t++) begin
      if_a.ready = (t == 0 || t == 14) ? 4'b0010 : 4'b0000;
      if_a.ack   = (t == 26) ? 4'b0010 : 4'b0000;
      step();
    end
`endif

    if_a.ready = '0; if_a.ack = '0;
    repeat (5) step();
    foreach (exp_q[k]) begin
      check($sformatf("missing_d%0d_ch%0d_%s", exp_q[k].dut, exp_q[k].ch, kname(exp_q[k].kind)),
            -1, exp_q[k].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_mc.md
HANDSHAKE_MC -- requirements
Module: handshake_mc

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent handshake channels (1..16).
REQ-002 SHALL have parameter PREP_CYCLES, default 4: data-preparation cycles between accepting ready and raising req (0..255).
REQ-003 SHALL have parameter FOUR_PHASE, default 0: 0 = ack completes the transfer; 1 = completion also requires ack to return low.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64: req-high cycles allowed before abort (1..65535); used only with HS_TIMEOUT_EN.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port ready, input, NCH: per-channel producer has data (for example, sfp_row not empty).
REQ-008 SHALL have port ack, input, NCH: per-channel consumer acknowledge.
REQ-009 SHALL have port req, output, NCH: per-channel request; high only in the SEND state.
REQ-010 SHALL have port busy, output, NCH: high whenever the channel is not in IDLE.
REQ-011 SHALL have port done, output, NCH: one-cycle pulse when a channel completes a handshake.
REQ-012 SHALL have port timeout, output, NCH: one-cycle abort pulse; present only with HS_TIMEOUT_EN.

Function
REQ-013 Each channel SHALL run its own FSM with states IDLE, PREP, SEND and RELEASE; channels SHALL share no state.
REQ-014 IDLE SHALL move to PREP when ready=1 and PREP_CYCLES>0, or directly to SEND when ready=1 and PREP_CYCLES=0.
REQ-015 On entry to PREP, the prep counter SHALL be 0; it SHALL increment each PREP cycle and move to SEND when it equals PREP_CYCLES-1, giving exactly PREP_CYCLES cycles in PREP.
REQ-016 The prep counter SHALL be $clog2(PREP_CYCLES+1) bits wide, SHALL be cleared in every state other than PREP, and SHALL never wrap.
REQ-017 Deassertion of ready during PREP or SEND SHALL be ignored; once accepted, the request SHALL run to completion or timeout.
REQ-018 ack SHALL be ignored in IDLE and PREP.
REQ-019 In SEND, ack=1 with FOUR_PHASE=0 SHALL move the channel to IDLE.
REQ-020 In SEND, ack=1 with FOUR_PHASE=1 SHALL move the channel to RELEASE, and req SHALL drop in the next cycle.
REQ-021 RELEASE SHALL hold until ack=0, then move to IDLE.
REQ-022 done[i] SHALL be registered and high for exactly the first cycle the channel is back in IDLE after a successful completion.
REQ-023 If ready=1 in that first IDLE cycle, a new request SHALL be accepted in the same cycle, giving back-to-back operation with no extra gap cycle.
REQ-024 req and busy SHALL be decoded from the registered state only, with no combinational path from ack or ready to any output.
REQ-025 Simultaneous events on different channels SHALL be handled independently in the same cycle.

Reset
REQ-026 When reset=1 at a clock edge, every channel SHALL go to IDLE; all counters, req, busy, done and timeout SHALL be 0 in the following cycle, including when reset arrives mid-PREP, mid-SEND or mid-RELEASE.
REQ-027 reset SHALL take priority over all other inputs.

Configuration
REQ-028 Macro HS_TIMEOUT_EN defined: in SEND a per-channel counter (16 bits, cleared outside SEND) SHALL count req-high cycles.
REQ-029 With HS_TIMEOUT_EN, after TIMEOUT_CYCLES cycles in SEND without ack, the channel SHALL go to IDLE with timeout[i] pulsed for one cycle and no done pulse.
REQ-030 With HS_TIMEOUT_EN, ack=1 in the expiry cycle SHALL win: the transfer completes normally with no timeout pulse.
REQ-031 Macro HS_TIMEOUT_EN undefined: the timeout port and counters SHALL be absent, and SEND SHALL wait indefinitely.

Verification
REQ-032 NCH=1, PREP_CYCLES=4, FOUR_PHASE=0: ready=1 at cycle 0 -> req high from cycle 5; ack=1 at cycle 7 -> req low and done=1 at cycle 8.
REQ-033 PREP_CYCLES=0: ready=1 at cycle 0 -> req=1 at cycle 1.
REQ-034 FOUR_PHASE=1: ack high for cycles 7-9 -> req low at cycle 8, busy held through cycle 10, done=1 at cycle 11.
REQ-035 NCH=4: ready=4'b1011 at once and ack driven per channel at different cycles -> each req and done matches the single-channel timing, with no cross-talk on channel 2.
REQ-036 Reset asserted during PREP at cycle 3 -> all outputs 0 at cycle 4; a new ready=1 at cycle 5 restarts with a full 4-cycle PREP.
REQ-037 HS_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack never asserted -> req high for exactly 8 cycles, then timeout=1 for one cycle and done=0; repeating with ack=1 in the 8th cycle -> done=1 and timeout=0.
